memristor_pulse_ctrl: RTL

MEMRISTOR_PULSE_CTRL -- requirements
Module: memristor_pulse_ctrl

---
 rtl/memristor_pulse_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/memristor_pulse_ctrl.sv
// Wishbone-programmable pulse sequencer driving memristor pattern/select pads.
// Optional done interrupt (irq_o, CTRL.irq_en) is built when MEMRISTOR_PULSE_IRQ_EN is defined.
module memristor_pulse_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic [4:0]  mem_ctrl_o,
    output logic        mem_sel_o,
    output logic [5:0]  mem_oeb_o,
    output logic        busy_o
`ifdef MEMRISTOR_PULSE_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_PULSE, S_GAP, S_DONE} state_t;

    state_t           state;
    logic [4:0]       pattern;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] gap;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] tmr;
    logic             sel;
    logic             done;
    logic             ack_block;
    logic             irq_en;

`ifdef MEMRISTOR_PULSE_IRQ_EN
    logic             irq_pend;
    assign irq_o = irq_pend & irq_en;
`else
    assign irq_en = 1'b0;
`endif

    logic [31:0] ctrl_val;
    logic [31:0] rd_data;
    logic [31:0] wr_old;
    logic [31:0] wr_data;
    logic        req;
    logic        wr_ctrl;
    logic        wr_pat;
    logic        wr_tim;
    logic        wr_cnt;
    logic        start;
    logic        abort;

    // ack_block keeps a bus cycle that straddled reset from ever being acked
    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~ack_block
                   & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl = req & wbs_we_i & (wbs_adr_i[3:0] == 4'h0);
    assign wr_pat  = req & wbs_we_i & (wbs_adr_i[3:0] == 4'h4);
    assign wr_tim  = req & wbs_we_i & (wbs_adr_i[3:0] == 4'h8);
    assign wr_cnt  = req & wbs_we_i & (wbs_adr_i[3:0] == 4'hC);
    assign start   = wr_ctrl & wr_data[0];
    assign abort   = wr_ctrl & wr_data[2];

    assign ctrl_val = {28'd0, irq_en, 1'b0, sel, 1'b0};

    // Register readback and byte-lane merge of write data onto the addressed register
    always_comb begin
        rd_data = '0;
        wr_old  = '0;
        case (wbs_adr_i[3:0])
            4'h0: begin
                rd_data = ctrl_val;
                wr_old  = ctrl_val;
            end
            4'h4: begin
                rd_data = 32'(pattern);
                wr_old  = 32'(pattern);
            end
            4'h8: begin
                rd_data = {16'(gap), 16'(width)};
                wr_old  = {16'(gap), 16'(width)};
            end
            4'hC: begin
                rd_data = {busy_o, done, 14'd0, 16'(remaining)};
                wr_old  = 32'(count);
            end
            default: ;
        endcase
        for (int b = 0; b < 4; b++) begin
            wr_data[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : wr_old[8*b +: 8];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            pattern    <= '0;
            width      <= '0;
            gap        <= '0;
            count      <= '0;
            remaining  <= '0;
            tmr        <= '0;
            sel        <= 1'b0;
            done       <= 1'b0;
            ack_block  <= 1'b1;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            mem_ctrl_o <= '0;
            mem_sel_o  <= 1'b0;
            mem_oeb_o  <= 6'h3F;
            busy_o     <= 1'b0;
`ifdef MEMRISTOR_PULSE_IRQ_EN
            irq_en     <= 1'b0;
            irq_pend   <= 1'b0;
`endif
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rd_data : '0;
            ack_block <= ack_block & wbs_cyc_i;

            // Configuration is frozen while a sequence is running
            if (!busy_o) begin
                if (wr_pat)  pattern <= wr_data[4:0];
                if (wr_tim) begin
                    width <= wr_data[CNT_W-1:0];
                    gap   <= wr_data[16 +: CNT_W];
                end
                if (wr_cnt)  count <= wr_data[CNT_W-1:0];
                if (wr_ctrl) sel   <= wr_data[1];
            end
`ifdef MEMRISTOR_PULSE_IRQ_EN
            if (wr_ctrl) irq_en   <= wr_data[3];
            if (wr_cnt)  irq_pend <= 1'b0;
`endif

            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                mem_ctrl_o <= '0;
                mem_sel_o  <= 1'b0;
                mem_oeb_o  <= 6'h3F;
                busy_o     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort && count != '0 && width != '0) begin
                            state      <= S_ARM;
                            busy_o     <= 1'b1;
                            mem_oeb_o  <= 6'h00;
                            mem_sel_o  <= wr_data[1];
                            mem_ctrl_o <= '0;
                            remaining  <= count;
                            done       <= 1'b0;
`ifdef MEMRISTOR_PULSE_IRQ_EN
                            irq_pend   <= 1'b0;
`endif
                        end
                    end
                    S_ARM: begin
                        state      <= S_PULSE;
                        tmr        <= width - CNT_W'(1);
                        mem_ctrl_o <= pattern;
                    end
                    S_PULSE: begin
                        if (tmr != '0) begin
                            tmr <= tmr - CNT_W'(1);
                        end else begin
                            remaining <= remaining - CNT_W'(1);
                            if (remaining > CNT_W'(1)) begin
                                if (gap != '0) begin
                                    state      <= S_GAP;
                                    tmr        <= gap - CNT_W'(1);
                                    mem_ctrl_o <= '0;
                                end else begin
                                    tmr <= width - CNT_W'(1);
                                end
                            end else begin
                                state      <= S_DONE;
                                mem_ctrl_o <= '0;
                                done       <= 1'b1;
`ifdef MEMRISTOR_PULSE_IRQ_EN
                                irq_pend   <= 1'b1;
`endif
                            end
                        end
                    end
                    S_GAP: begin
                        if (tmr != '0) begin
                            tmr <= tmr - CNT_W'(1);
                        end else begin
                            state      <= S_PULSE;
                            tmr        <= width - CNT_W'(1);
                            mem_ctrl_o <= pattern;
                        end
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        mem_sel_o <= 1'b0;
                        mem_oeb_o <= 6'h3F;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
